fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 143 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serializes each word as a
// UART frame: start bit, LSB-first data, optional even parity, stop bit.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] STOP   = 3'd6;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  parity_reg, parity_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [BAUD_W-1:0]     baud_reg, baud_next;
    logic                  tx_reg, tx_next;
    logic                  baud_done;

    assign baud_done = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        bit_cnt_next = bit_cnt_reg;
        baud_next    = baud_reg;
        case (state_reg)
            IDLE: begin
                baud_next    = '0;
                bit_cnt_next = '0;
                if (tx_en && !fifo_empty) begin
                    state_next = FETCH;
                end
            end
            // Sole reader of the FIFO, so the pop issued here always yields a word.
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next  = fifo_rd_data;
                parity_next = (PARITY_EN != 0) ? ^fifo_rd_data : 1'b0;
                baud_next   = '0;
                state_next  = START;
            end
            START: begin
                if (baud_done) begin
                    baud_next    = '0;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so the pad sees a flop output.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            baud_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            bit_cnt_reg <= bit_cnt_next;
            baud_reg    <= baud_next;
            tx_reg      <= tx_next;
        end
    end

    assign fifo_r_en  = (state_reg == FETCH);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == STOP) && baud_done;
    assign tx         = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (no parity / even parity) each fed by a
// small FIFO model with one-cycle registered read latency.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tx_en0, tx_en1;
    logic       empty0, empty1;
    logic [7:0] rd0, rd1;
    logic       ren0, ren1, tx0, tx1, busy0, busy1, done0, done1;

    logic [7:0] mem0 [0:15];
    logic [7:0] mem1 [0:15];
    logic [3:0] wr0 = '0, wr1 = '0, rp0 = '0, rp1 = '0;

    assign empty0 = (wr0 == rp0);
    assign empty1 = (wr1 == rp1);

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .fifo_empty(empty0),
        .fifo_rd_data(rd0), .fifo_r_en(ren0), .tx(tx0), .busy(busy0),
        .frame_done(done0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .fifo_empty(empty1),
        .fifo_rd_data(rd1), .fifo_r_en(ren1), .tx(tx1), .busy(busy1),
        .frame_done(done1)
    );

    // FIFO models: read enable sampled mid-cycle, pop and data update on the edge.
    logic ren_s0 = 1'b0, ren_s1 = 1'b0, ren_p0 = 1'b0, ren_p1 = 1'b0;
    int   ren_cnt0 = 0, ren_cnt1 = 0, viol0 = 0, viol1 = 0;

    always @(negedge clk) begin
        ren_s0 <= (ren0 === 1'b1);
        ren_s1 <= (ren1 === 1'b1);
    end

    always @(posedge clk) begin
        ren_p0 <= ren_s0;
        ren_p1 <= ren_s1;
        viol0  <= viol0 + int'(ren_s0 && empty0) + int'(ren_s0 && ren_p0);
        viol1  <= viol1 + int'(ren_s1 && empty1) + int'(ren_s1 && ren_p1);
        if (ren_s0) begin
            ren_cnt0 <= ren_cnt0 + 1;
            if (!empty0) begin
                rd0 <= mem0[rp0];
                rp0 <= rp0 + 4'd1;
            end
        end
        if (ren_s1) begin
            ren_cnt1 <= ren_cnt1 + 1;
            if (!empty1) begin
                rd1 <= mem1[rp1];
                rp1 <= rp1 + 4'd1;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic g_tx(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction
    function automatic logic g_ren(input int sel);
        return (sel != 0) ? ren1 : ren0;
    endfunction
    function automatic logic g_done(input int sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    task automatic push(input int sel, input logic [7:0] d);
        if (sel != 0) begin
            mem1[wr1] = d;
            wr1 = wr1 + 4'd1;
        end else begin
            mem0[wr0] = d;
            wr0 = wr0 + 4'd1;
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s_tx%0d", tag, sel), 32'(g_tx(sel)), 32'd1);
        check($sformatf("%s_busy%0d", tag, sel), 32'(g_busy(sel)), 32'd0);
        check($sformatf("%s_ren%0d", tag, sel), 32'(g_ren(sel)), 32'd0);
        check($sformatf("%s_done%0d", tag, sel), 32'(g_done(sel)), 32'd0);
    endtask

    // Entry: mid-cycle of an IDLE cycle with tx_en=1 and the FIFO non-empty.
    task automatic frame(input int sel, input logic [7:0] word, input int pen,
                         input int drop_at, input int abort_at);
        logic bitv [0:10];
        int   nb;
        nb = 10 + pen;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[i+1] = word[i];
        bitv[9]  = (pen != 0) ? ^word : 1'b1;
        bitv[10] = 1'b1;
        $display("frame dut%0d word=%02h parity_en=%0d drop_at=%0d abort_at=%0d",
                 sel, word, pen, drop_at, abort_at);
        check_idle(sel, "entry");
        @(negedge clk);
        check($sformatf("fetch_ren%0d", sel), 32'(g_ren(sel)), 32'd1);
        check($sformatf("fetch_busy%0d", sel), 32'(g_busy(sel)), 32'd1);
        check($sformatf("fetch_tx%0d", sel), 32'(g_tx(sel)), 32'd1);
        @(negedge clk);
        check($sformatf("load_ren%0d", sel), 32'(g_ren(sel)), 32'd0);
        check($sformatf("load_tx%0d", sel), 32'(g_tx(sel)), 32'd1);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (b * 4 + c == drop_at) begin
                    if (sel != 0) tx_en1 = 1'b0;
                    else          tx_en0 = 1'b0;
                end
                check($sformatf("tx%0d_w%02h_b%0d_c%0d", sel, word, b, c),
                      32'(g_tx(sel)), 32'(bitv[b]));
                check($sformatf("done%0d_w%02h_b%0d_c%0d", sel, word, b, c),
                      32'(g_done(sel)), 32'((b == nb - 1) && (c == 3)));
                check($sformatf("busy%0d_w%02h_b%0d_c%0d", sel, word, b, c),
                      32'(g_busy(sel)), 32'd1);
                check($sformatf("ren%0d_w%02h_b%0d_c%0d", sel, word, b, c),
                      32'(g_ren(sel)), 32'd0);
                if (b == abort_at && c == 1) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_idle(sel, "abort");
                    rst_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        tx_en0 = 1'b1;
        tx_en1 = 1'b1;

        // Reset with empty FIFOs and tx_en high.
        repeat (3) @(negedge clk);
        check_idle(0, "rst");
        check_idle(1, "rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0, "post_rst");
        check_idle(1, "post_rst");
        check("ren_cnt0_rst", 32'(ren_cnt0), 32'd0);
        check("ren_cnt1_rst", 32'(ren_cnt1), 32'd0);

        // Single word, no parity.
        push(0, 8'hA5);
        frame(0, 8'hA5, 0, -1, -1);
        @(negedge clk);
        check_idle(0, "after_a5");
        check("ren_cnt0_single", 32'(ren_cnt0), 32'd1);

        // Even parity: 0xA5 -> 0, 0x07 -> 1.
        push(1, 8'hA5);
        frame(1, 8'hA5, 1, -1, -1);
        @(negedge clk);
        push(1, 8'h07);
        frame(1, 8'h07, 1, -1, -1);
        @(negedge clk);
        check_idle(1, "after_par");
        check("ren_cnt1_par", 32'(ren_cnt1), 32'd2);

        // Back-to-back frames with the minimum 3-cycle idle-high gap.
        push(0, 8'h01);
        push(0, 8'h80);
        push(0, 8'hFF);
        frame(0, 8'h01, 0, -1, -1);
        @(negedge clk);
        frame(0, 8'h80, 0, -1, -1);
        @(negedge clk);
        frame(0, 8'hFF, 0, -1, -1);
        @(negedge clk);
        check_idle(0, "after_b2b");
        check("ren_cnt0_b2b", 32'(ren_cnt0), 32'd4);

        // tx_en dropped during data bit 3 of 0x3C with two words still queued.
        push(0, 8'h3C);
        push(0, 8'hAA);
        push(0, 8'h55);
        frame(0, 8'h3C, 0, 12, -1);
        repeat (8) begin
            @(negedge clk);
            check_idle(0, "txen_off");
        end
        check("ren_cnt0_txen_off", 32'(ren_cnt0), 32'd5);

        // Reset during the 4th data bit of 0xAA; 0x55 must follow intact.
        @(negedge clk);
        tx_en0 = 1'b1;
        frame(0, 8'hAA, 0, -1, 4);
        frame(0, 8'h55, 0, -1, -1);
        @(negedge clk);
        check_idle(0, "after_abort");
        check("ren_cnt0_final", 32'(ren_cnt0), 32'd7);
        check("fifo0_drained", 32'(empty0), 32'd1);
        check("viol0", 32'(viol0), 32'd0);
        check("viol1", 32'(viol1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
